// File: rtl/struct_record_serializer_if.sv
// Record-in / word-out handshake bundle for struct_record_serializer.
//   slave  : serializer view (takes records, drives output words)
//   master : environment view (offers records, consumes output words)
// Record side : i_valid, o_ready, i_a, i_aa, i_aaa, i_kind, i_order, o_drop
// Word side   : o_valid, i_ready, o_data, o_last
interface struct_record_serializer_if;
  logic        i_valid;
  logic        o_ready;
  logic [9:0]  i_a;
  logic [9:0]  i_aa;
  logic [31:0] i_aaa;
  logic [1:0]  i_kind;
  logic        i_order;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_last;
  logic        o_drop;

  modport slave (
    input  i_valid, i_a, i_aa, i_aaa, i_kind, i_order, i_ready,
    output o_ready, o_valid, o_data, o_last, o_drop
  );

  modport master (
    output i_valid, i_a, i_aa, i_aaa, i_kind, i_order, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_drop
  );
endinterface

// File: rtl/struct_record_serializer.sv
// Serializes one (a, aa, aaa, kind) record per handshake into a framed
// stream of 16-bit words: header, then 1/2/4 payload words by kind.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : struct_record_serializer_if.slave (record in, words out)
// Parameter SEQ_WIDTH (1..12): width of the per-frame sequence counter.
module struct_record_serializer #(
  parameter int unsigned SEQ_WIDTH = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  struct_record_serializer_if.slave bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned HDR_SEQ_W = 12;
  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_X    = 2'd1;
  localparam logic [1:0] KIND_Y    = 2'd2;

  typedef enum logic [2:0] {IDLE, HDR, WA, WAA, WAAA0, WAAA1} state_t;

  state_t               state, state_nxt;
  logic [SEQ_WIDTH-1:0] seq, seq_nxt;
  logic [9:0]           a_q, aa_q;
  logic [31:0]          aaa_q;
  logic [1:0]           kind_q;
  logic                 order_q;
  logic                 load;
  logic                 done;
  logic                 advance;
  logic                 valid_nxt, last_nxt, ready_nxt, drop_nxt;
  logic [DATA_W-1:0]    data_nxt;

  // State, counter, captured record and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      seq         <= '0;
      a_q         <= '0;
      aa_q        <= '0;
      aaa_q       <= '0;
      kind_q      <= '0;
      order_q     <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_last  <= 1'b0;
      bus.o_drop  <= 1'b0;
      bus.o_ready <= 1'b1;
    end else begin
      state       <= state_nxt;
      seq         <= seq_nxt;
      bus.o_valid <= valid_nxt;
      bus.o_data  <= data_nxt;
      bus.o_last  <= last_nxt;
      bus.o_drop  <= drop_nxt;
      bus.o_ready <= ready_nxt;
      if (load) begin
        a_q     <= bus.i_a;
        aa_q    <= bus.i_aa;
        aaa_q   <= bus.i_aaa;
        kind_q  <= bus.i_kind;
        order_q <= bus.i_order;
      end
    end
  end

  // Next state and next output word; each word is computed one step ahead
  // so it appears on the bus right after the handshake that advances to it.
  always_comb begin
    state_nxt = state;
    seq_nxt   = seq;
    valid_nxt = bus.o_valid;
    data_nxt  = bus.o_data;
    last_nxt  = bus.o_last;
    ready_nxt = bus.o_ready;
    drop_nxt  = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    advance   = bus.o_valid && bus.i_ready;

    unique case (state)
      IDLE: begin
        if (bus.i_valid && bus.o_ready) begin
          load = 1'b1;
          if (bus.i_kind == KIND_NONE) begin
            drop_nxt = 1'b1;
          end else begin
            state_nxt = HDR;
            valid_nxt = 1'b1;
            data_nxt  = {bus.i_kind, 2'b00, HDR_SEQ_W'(seq)};
            last_nxt  = 1'b0;
            ready_nxt = 1'b0;
          end
        end
      end
      HDR: begin
        if (advance) begin
          state_nxt = WA;
          data_nxt  = DATA_W'(a_q);
          last_nxt  = (kind_q == KIND_X);
        end
      end
      WA: begin
        if (advance) begin
          if (kind_q == KIND_X) begin
            done = 1'b1;
          end else begin
            state_nxt = WAA;
            data_nxt  = DATA_W'(aa_q);
            last_nxt  = (kind_q == KIND_Y);
          end
        end
      end
      WAA: begin
        if (advance) begin
          if (kind_q == KIND_Y) begin
            done = 1'b1;
          end else begin
            state_nxt = WAAA0;
            data_nxt  = order_q ? aaa_q[31:16] : aaa_q[15:0];
            last_nxt  = 1'b0;
          end
        end
      end
      WAAA0: begin
        if (advance) begin
          state_nxt = WAAA1;
          data_nxt  = order_q ? aaa_q[15:0] : aaa_q[31:16];
          last_nxt  = 1'b1;
        end
      end
      WAAA1: begin
        if (advance) done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Final-word handshake: close the frame and bump the sequence number.
    if (done) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      data_nxt  = '0;
      last_nxt  = 1'b0;
      ready_nxt = 1'b1;
      seq_nxt   = seq + SEQ_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_struct_record_serializer.sv
// Self-checking bench for struct_record_serializer: a scoreboard of expected
// {last, data} words is filled when records are sent and drained against
// the words observed on the output handshake. A second instance with
// SEQ_WIDTH=2 shares the stimulus and is used for the wrap check.
module tb_struct_record_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   seq_model;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  struct_record_serializer_if u_if ();
  struct_record_serializer_if u_if2 ();

  struct_record_serializer #(.SEQ_WIDTH(12)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  assign u_if2.i_valid = u_if.i_valid;
  assign u_if2.i_a     = u_if.i_a;
  assign u_if2.i_aa    = u_if.i_aa;
  assign u_if2.i_aaa   = u_if.i_aaa;
  assign u_if2.i_kind  = u_if.i_kind;
  assign u_if2.i_order = u_if.i_order;
  assign u_if2.i_ready = u_if.i_ready;

  struct_record_serializer #(.SEQ_WIDTH(2)) u_dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq_model = 0;
  endtask

  // Expected words of one frame, from the documented layout.
  task automatic push_frame(input logic [9:0] a, input logic [9:0] aa,
                            input logic [31:0] aaa, input logic [1:0] kind,
                            input logic order);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = aaa[15:0];
    hi = aaa[31:16];
    exp_q.push_back({1'b0, kind, 2'b00, 12'(seq_model)});
    exp_q.push_back({kind == 2'd1, 6'b0, a});
    if (kind != 2'd1) exp_q.push_back({kind == 2'd2, 6'b0, aa});
    if (kind == 2'd3) begin
      exp_q.push_back({1'b0, order ? hi : lo});
      exp_q.push_back({1'b1, order ? lo : hi});
    end
    seq_model = seq_model + 1;
  endtask

  // Offer a record at a negedge; return at the negedge after acceptance,
  // with the upstream inputs scrambled to prove they are not reused.
  task automatic send(input logic [9:0] a, input logic [9:0] aa,
                      input logic [31:0] aaa, input logic [1:0] kind,
                      input logic order);
    u_if.i_a     = a;
    u_if.i_aa    = aa;
    u_if.i_aaa   = aaa;
    u_if.i_kind  = kind;
    u_if.i_order = order;
    u_if.i_valid = 1'b1;
    for (int k = 0; k < 60 && !u_if.o_ready; k++) @(negedge clk);
    @(negedge clk);
    u_if.i_valid = 1'b0;
    u_if.i_a     = 10'($urandom);
    u_if.i_aa    = 10'($urandom);
    u_if.i_aaa   = $urandom;
    u_if.i_kind  = 2'($urandom);
    u_if.i_order = 1'($urandom);
  endtask

  // Gather handshaken words into got_q until it holds n entries (bounded);
  // bad counts words that changed while stalled.
  task automatic collect(input int n, input bit toggle, output int bad);
    logic [16:0] held;
    bit held_v;
    int cyc;
    bad = 0;
    held_v = 1'b0;
    held = '0;
    cyc = 0;
    while (got_q.size() < n && cyc < 60) begin
      u_if.i_ready = toggle ? cyc[0] : 1'b1;
      if (held_v && u_if.o_valid && {u_if.o_last, u_if.o_data} !== held) bad++;
      held_v = u_if.o_valid && !u_if.i_ready;
      held = {u_if.o_last, u_if.o_data};
      if (u_if.o_valid && u_if.i_ready) got_q.push_back({u_if.o_last, u_if.o_data});
      cyc++;
      @(negedge clk);
    end
    u_if.i_ready = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (u_if.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", u_if.o_valid); end
    if (u_if.o_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h want=0000", u_if.o_data); end
    if (u_if.o_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", u_if.o_last); end
    if (u_if.o_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b want=0", u_if.o_drop); end
    if (u_if.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", u_if.o_ready); end
  endtask

  task automatic test_single_bz();
    int bad;
    logic [16:0] e;
    logic [16:0] g;
    exp_q.delete(); got_q.delete();
    push_frame(10'h155, 10'h0AA, 32'h12345678, 2'd3, 1'b0);
    send(10'h155, 10'h0AA, 32'h12345678, 2'd3, 1'b0);
    collect(5, 1'b0, bad);
    checks++;
    if (got_q.size() !== 5) begin failures++; $display("FAIL bz_count got=%0d want=5", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 17'bx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL bz_word got=%h want=%h", g, e); end
    end
    checks++;
    if (u_if.o_ready !== 1'b1) begin failures++; $display("FAIL bz_ready_after got=%b want=1", u_if.o_ready); end
  endtask

  task automatic test_order_kinds();
    int bad;
    logic [16:0] e;
    logic [16:0] g;
    exp_q.delete(); got_q.delete();
    push_frame(10'h155, 10'h0AA, 32'h12345678, 2'd3, 1'b1);
    send(10'h155, 10'h0AA, 32'h12345678, 2'd3, 1'b1);
    collect(5, 1'b0, bad);
    push_frame(10'h3FF, 10'h000, 32'h0, 2'd1, 1'b0);
    send(10'h3FF, 10'h000, 32'h0, 2'd1, 1'b0);
    collect(7, 1'b0, bad);
    push_frame(10'h001, 10'h002, 32'h0, 2'd2, 1'b0);
    send(10'h001, 10'h002, 32'h0, 2'd2, 1'b0);
    collect(10, 1'b0, bad);
    checks++;
    if (got_q.size() !== 10) begin failures++; $display("FAIL kinds_count got=%0d want=10", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 17'bx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL kinds_word got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [16:0] e;
    logic [16:0] g;
    exp_q.delete(); got_q.delete();
    push_frame(10'h2A5, 10'h15A, 32'hCAFEF00D, 2'd3, 1'b0);
    send(10'h2A5, 10'h15A, 32'hCAFEF00D, 2'd3, 1'b0);
    checks++;
    if (u_if.o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_busy got=%b want=0", u_if.o_ready); end
    collect(5, 1'b1, bad);
    checks += 2;
    if (bad !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d changes want=0", bad); end
    if (got_q.size() !== 5) begin failures++; $display("FAIL bp_handshakes got=%0d want=5", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 17'bx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL bp_word got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_drop();
    int bad;
    logic [16:0] e;
    logic [16:0] g;
    exp_q.delete(); got_q.delete();
    send(10'h111, 10'h222, 32'h33334444, 2'd0, 1'b0);
    checks += 2;
    if (u_if.o_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b want=1", u_if.o_drop); end
    if (u_if.o_valid !== 1'b0) begin failures++; $display("FAIL drop_valid got=%b want=0", u_if.o_valid); end
    @(negedge clk);
    checks += 2;
    if (u_if.o_drop !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%b want=0", u_if.o_drop); end
    if (u_if.o_valid !== 1'b0) begin failures++; $display("FAIL drop_valid2 got=%b want=0", u_if.o_valid); end
    push_frame(10'h0C3, 10'h000, 32'h0, 2'd1, 1'b0);
    send(10'h0C3, 10'h000, 32'h0, 2'd1, 1'b0);
    collect(2, 1'b0, bad);
    checks++;
    if (got_q.size() !== 2) begin failures++; $display("FAIL drop_next_count got=%0d want=2", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 17'bx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL drop_next_word got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_abort();
    int bad;
    int seen;
    logic [16:0] e;
    logic [16:0] g;
    exp_q.delete(); got_q.delete();
    u_if.i_ready = 1'b1;
    send(10'h011, 10'h022, 32'hAAAABBBB, 2'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (u_if.o_data !== 16'h0022) begin failures++; $display("FAIL abort_at_waa got=%h want=0022", u_if.o_data); end
    rst = 1'b1;
    #1;
    checks += 2;
    if (u_if.o_valid !== 1'b0) begin failures++; $display("FAIL abort_async_valid got=%b want=0", u_if.o_valid); end
    if (u_if.o_last !== 1'b0) begin failures++; $display("FAIL abort_async_last got=%b want=0", u_if.o_last); end
    @(negedge clk);
    rst = 1'b0;
    seq_model = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (u_if.o_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_resume got=%0d valid cycles want=0", seen); end
    push_frame(10'h00F, 10'h000, 32'h0, 2'd1, 1'b0);
    send(10'h00F, 10'h000, 32'h0, 2'd1, 1'b0);
    collect(2, 1'b0, bad);
    checks++;
    if (got_q.size() !== 2) begin failures++; $display("FAIL abort_next_count got=%0d want=2", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 17'bx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL abort_next_word got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_seq_wrap();
    int bad;
    logic [16:0] e;
    logic [16:0] g;
    logic [11:0] want2;
    exp_q.delete(); got_q.delete();
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      want2 = 12'(f % 4);
      push_frame(10'(f), 10'h000, 32'h0, 2'd1, 1'b0);
      send(10'(f), 10'h000, 32'h0, 2'd1, 1'b0);
      checks++;
      if (u_if2.o_valid !== 1'b1 || u_if2.o_data !== {4'b0100, want2}) begin
        failures++;
        $display("FAIL wrap_hdr frame=%0d got=%b/%h want=1/%h", f, u_if2.o_valid, u_if2.o_data, {4'b0100, want2});
      end
      collect(2 * (f + 1), 1'b0, bad);
    end
    checks++;
    if (got_q.size() !== 10) begin failures++; $display("FAIL wrap_count got=%0d want=10", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 17'bx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL wrap_w12_word got=%h want=%h", g, e); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    seq_model = 0;
    rst = 1'b1;
    u_if.i_valid = 1'b0;
    u_if.i_a = '0;
    u_if.i_aa = '0;
    u_if.i_aaa = '0;
    u_if.i_kind = '0;
    u_if.i_order = 1'b0;
    u_if.i_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_bz();
    test_order_kinds();
    test_backpressure();
    test_drop();
    test_abort();
    test_seq_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
